// File: rtl/mycpu_pkg.sv
// Shared pipeline constants and types for the LoongArch core.
// Scoreboard sizing lives here so decode and the scoreboard agree on widths.
package mycpu_pkg;

    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int SB_CNT_W   = 2;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: pending-write counter plus a "youngest producer is a load" bit.
// Error pulses are combinational; the top level makes them sticky.
module sb_entry
    import mycpu_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_iss_hit,
    input  logic             i_iss_ld,
    input  logic             i_ret_hit,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last_ld,
    output logic             o_err_ovf,
    output logic             o_err_udf
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_last_ld;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_last_ld_nxt;

    // Next-state: flush dominates, a paired issue+retire nets to zero change.
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_last_ld_nxt = r_last_ld;
        if (i_flush) begin
            w_cnt_nxt     = CNT_ZERO;
            w_last_ld_nxt = 1'b0;
        end else if (i_iss_hit && i_ret_hit) begin
            w_last_ld_nxt = i_iss_ld;
        end else if (i_iss_hit) begin
            w_cnt_nxt     = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
            w_last_ld_nxt = i_iss_ld;
        end else if (i_ret_hit) begin
            w_cnt_nxt     = (r_cnt == CNT_ZERO) ? CNT_ZERO : r_cnt - CNT_ONE;
            w_last_ld_nxt = (w_cnt_nxt == CNT_ZERO) ? 1'b0 : r_last_ld;
        end else begin
            w_cnt_nxt     = r_cnt;
            w_last_ld_nxt = r_last_ld;
        end
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= CNT_ZERO;
            r_last_ld <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_last_ld <= w_last_ld_nxt;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_last_ld = r_last_ld;
    assign o_err_ovf = !i_flush && i_iss_hit && !i_ret_hit && (r_cnt == CNT_MAX);
    assign o_err_udf = !i_flush && i_ret_hit && !i_iss_hit && (r_cnt == CNT_ZERO);

endmodule

// File: rtl/reg_scoreboard.sv
// Per-GPR pending-write scoreboard between ID issue and WB retire.
// Queries see registered state only; r0 is never tracked.
module reg_scoreboard
    import mycpu_pkg::*;
#(
    parameter int NREG  = mycpu_pkg::NREG,
    parameter int CNT_W = mycpu_pkg::SB_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iss_valid,
    input  logic                  iss_we,
    input  logic [REG_ADDR_W-1:0] iss_dest,
    input  logic                  iss_is_load,
    input  logic                  ret_we,
    input  logic [REG_ADDR_W-1:0] ret_waddr,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] q_raddr1,
    input  logic [REG_ADDR_W-1:0] q_raddr2,
    output logic                  q_busy1,
    output logic                  q_busy2,
    output logic                  q_load1,
    output logic                  q_load2,
    output logic                  idle,
    output logic                  err
);

    logic [CNT_W-1:0] w_cnt     [NREG];
    logic             w_last_ld [NREG];
    logic [NREG-1:0]  w_ovf;
    logic [NREG-1:0]  w_udf;
    logic             w_iss_en;
    logic             w_busy_any;
    logic             r_err;

    assign w_iss_en     = iss_valid && iss_we;
    assign w_cnt[0]     = {CNT_W{1'b0}};
    assign w_last_ld[0] = 1'b0;
    assign w_ovf[0]     = 1'b0;
    assign w_udf[0]     = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_entry
        sb_entry #(.CNT_W(CNT_W)) u_entry (
            .clk       (clk),
            .reset     (reset),
            .i_iss_hit (w_iss_en && (iss_dest == REG_ADDR_W'(g))),
            .i_iss_ld  (iss_is_load),
            .i_ret_hit (ret_we && (ret_waddr == REG_ADDR_W'(g))),
            .i_flush   (flush),
            .o_cnt     (w_cnt[g]),
            .o_last_ld (w_last_ld[g]),
            .o_err_ovf (w_ovf[g]),
            .o_err_udf (w_udf[g])
        );
    end

    // Any slot with a pending write keeps the pipeline from being idle.
    always_comb begin
        w_busy_any = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            w_busy_any = w_busy_any | (w_cnt[i] != {CNT_W{1'b0}});
        end
    end

    // Sticky error: only reset clears it, flush deliberately does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (|w_ovf) | (|w_udf);
        end
    end

    assign q_busy1 = (w_cnt[q_raddr1] != {CNT_W{1'b0}});
    assign q_busy2 = (w_cnt[q_raddr2] != {CNT_W{1'b0}});
    assign q_load1 = q_busy1 & w_last_ld[q_raddr1];
    assign q_load2 = q_busy2 & w_last_ld[q_raddr2];
    assign idle    = ~w_busy_any;
    assign err     = r_err;

endmodule
